// File: rtl/inc_dec_unit_if.sv
// inc_dec_unit_if: request/result handshake bundle for inc_dec_unit
interface inc_dec_unit_if #(parameter int WIDTH = 8, parameter int STEP_W = 4);
  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [WIDTH-1:0]  a;
  logic [STEP_W-1:0] step;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              ovf;
  logic              zero;
  modport master (
    output en, in_valid, op, a, step, out_ready,
    input  in_ready, out_valid, result, ovf, zero
  );
  modport slave (
    input  en, in_valid, op, a, step, out_ready,
    output in_ready, out_valid, result, ovf, zero
  );
endinterface

// File: rtl/inc_dec_unit.sv
// inc_dec_unit: registered incrementer/decrementer with accumulator; INC_DEC_SAT_EN selects saturating arithmetic
module inc_dec_unit #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  inc_dec_unit_if.slave bus
);
  typedef enum logic [1:0] {INC, DEC, ACC_INC, CLR} op_t;
  logic [WIDTH-1:0] acc, step_x, nxt;
  logic [WIDTH:0]   sum;
  logic             accept;
  assign step_x     = WIDTH'(bus.step);
  assign bus.in_ready = bus.en && (!bus.out_valid || bus.out_ready);
  assign accept     = bus.in_valid && bus.in_ready;
  // Carry/borrow lands in the extra top bit of the widened sum
  always_comb
    sum = bus.op == INC     ? {1'b0, bus.a} + {1'b0, step_x} :
          bus.op == DEC     ? {1'b0, bus.a} - {1'b0, step_x} :
          bus.op == ACC_INC ? {1'b0, acc} + {1'b0, step_x} : '0;
`ifdef INC_DEC_SAT_EN
  assign nxt = !sum[WIDTH] ? sum[WIDTH-1:0] : bus.op == DEC ? '0 : '1;
`else
  assign nxt = sum[WIDTH-1:0];
`endif
  // Load result, flags and accumulator on accept; drop out_valid when drained
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
      acc           <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.result    <= nxt;
      bus.ovf       <= sum[WIDTH];
      bus.zero      <= nxt == '0;
      acc           <= nxt;
    end else if (bus.out_ready)
      bus.out_valid <= 1'b0;
endmodule

// File: tb/tb_inc_dec_unit.sv
// tb_inc_dec_unit: directed vector bench for inc_dec_unit (WIDTH=8, STEP_W=4)
module tb_inc_dec_unit;
`ifdef INC_DEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [1:0] INC = 2'd0, DEC = 2'd1, ACC = 2'd2, CLR = 2'd3;
  logic clk = 1'b0;
  logic rst_n;
  int passed = 0, total = 0;
  inc_dec_unit_if #(.WIDTH(8), .STEP_W(4)) bus ();
  inc_dec_unit #(.WIDTH(8), .STEP_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [3:0] step;
    logic [7:0] res;
    logic       ovf;
    logic       zero;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [3:0] step);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.step = step;
  endtask
  task automatic chk_out(input string nm, input logic [7:0] res, input logic ovf, input logic zero, input logic vld);
    chk({nm, ".result"}, 32'(bus.result), 32'(res));
    chk({nm, ".ovf"}, 32'(bus.ovf), 32'(ovf));
    chk({nm, ".zero"}, 32'(bus.zero), 32'(zero));
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
  endtask
  initial begin
    v[0]  = '{INC, 8'h0F, 4'd1,  8'h10, 1'b0, 1'b0};
    v[1]  = '{INC, 8'hFF, 4'd1,  SAT ? 8'hFF : 8'h00, 1'b1, !SAT};
    v[2]  = '{DEC, 8'h02, 4'd4,  SAT ? 8'h00 : 8'hFE, 1'b1, SAT};
    v[3]  = '{INC, 8'h37, 4'd0,  8'h37, 1'b0, 1'b0};
    v[4]  = '{DEC, 8'h05, 4'd5,  8'h00, 1'b0, 1'b1};
    v[5]  = '{DEC, 8'h00, 4'd0,  8'h00, 1'b0, 1'b1};
    v[6]  = '{CLR, 8'hAA, 4'd7,  8'h00, 1'b0, 1'b1};
    v[7]  = '{ACC, 8'h99, 4'd5,  8'h05, 1'b0, 1'b0};
    v[8]  = '{ACC, 8'h99, 4'd5,  8'h0A, 1'b0, 1'b0};
    v[9]  = '{ACC, 8'h99, 4'd5,  8'h0F, 1'b0, 1'b0};
    v[10] = '{INC, 8'hFA, 4'hF,  SAT ? 8'hFF : 8'h09, 1'b1, 1'b0};
    v[11] = '{ACC, 8'h00, 4'd3,  SAT ? 8'hFF : 8'h0C, SAT, 1'b0};
    v[12] = '{DEC, 8'h80, 4'hF,  8'h71, 1'b0, 1'b0};
    v[13] = '{ACC, 8'h00, 4'hF,  8'h80, 1'b0, 1'b0};
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = INC;
    bus.a = '0;
    bus.step = '0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 14; i++) begin
      drive(v[i].op, v[i].a, v[i].step);
      cyc();
      chk_out($sformatf("vec%0d", i), v[i].res, v[i].ovf, v[i].zero, 1'b1);
    end
    bus.in_valid = 1'b0;
    cyc();
    chk_out("drain", 8'h80, 1'b0, 1'b0, 1'b0);
    drive(INC, 8'h20, 4'd1);
    cyc();
    chk_out("stall_load", 8'h21, 1'b0, 1'b0, 1'b1);
    drive(INC, 8'h40, 4'd2);
    bus.out_ready = 1'b0;
    #1;
    chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out($sformatf("stall%0d", i), 8'h21, 1'b0, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    chk_out("release", 8'h42, 1'b0, 1'b0, 1'b1);
    bus.en = 1'b0;
    bus.out_ready = 1'b0;
    drive(INC, 8'h01, 4'd1);
    #1;
    chk("en0.in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    chk_out("en0_hold", 8'h42, 1'b0, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    cyc();
    chk_out("en0_drain", 8'h42, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b1;
    drive(INC, 8'h10, 4'd1);
    cyc();
    chk_out("pre_rst", 8'h11, 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(ACC, 8'hEE, 4'd1);
    cyc();
    chk_out("acc_after_rst", 8'h01, 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
